// File: rtl/branch_target_pc_sequencer_if.sv
// branch_target_pc_sequencer_if: fetch-side bus between execute, the branch destination register and fetch.
interface branch_target_pc_sequencer_if #(
    parameter int unsigned AddrBits = 32
);
    logic                ce;
    logic                tick;
    logic                branch_taken;
    logic [AddrBits-1:0] branch_target_q;
    logic                branch_target_cs;
    logic                halt;
    logic                fetch_ready;
    logic [AddrBits-1:0] pc;
    logic                pc_valid;
    logic                flush;
    logic                redirected;

    modport master (
        output ce, tick, branch_taken, branch_target_q, halt, fetch_ready,
        input  branch_target_cs, pc, pc_valid, flush, redirected
    );

    modport slave (
        input  ce, tick, branch_taken, branch_target_q, halt, fetch_ready,
        output branch_target_cs, pc, pc_valid, flush, redirected
    );
endinterface

// File: rtl/branch_target_pc_sequencer.sv
// branch_target_pc_sequencer: owns the fetch PC, loads taken-branch targets and flushes fetch afterwards.
module branch_target_pc_sequencer #(
    parameter int unsigned         AddrBits    = 32,
    parameter int unsigned         PcIncrement = 4,
    parameter logic [AddrBits-1:0] ResetVector = '0,
    parameter int unsigned         FlushCycles = 2
) (
    input logic                         clk_i,
    input logic                         rst_ni,
    branch_target_pc_sequencer_if.slave bus
);
    localparam int unsigned CntBits = (FlushCycles > 1) ? $clog2(FlushCycles) : 1;
    localparam logic [CntBits-1:0] CntInit = CntBits'(FlushCycles - 1);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALTED} state_e;

    state_e              state_q, state_d;
    logic [AddrBits-1:0] pc_q, pc_d;
    logic                pc_valid_q, pc_valid_d;
    logic                flush_q, flush_d;
    logic                redirected_q, redirected_d;
    logic [CntBits-1:0]  cnt_q, cnt_d;
    logic                step;
    logic                take;

    assign step = bus.ce & bus.tick;
    // The register drives Q only in the cycle the target is consumed; reset forces it off.
    assign take = (state_q == RUN) & bus.branch_taken & step;
    assign bus.branch_target_cs = ~(take & rst_ni);

    assign bus.pc         = pc_q;
    assign bus.pc_valid   = pc_valid_q;
    assign bus.flush      = flush_q;
    assign bus.redirected = redirected_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= BOOT;
            pc_q         <= ResetVector;
            pc_valid_q   <= 1'b0;
            flush_q      <= 1'b0;
            redirected_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pc_valid_q   <= pc_valid_d;
            flush_q      <= flush_d;
            redirected_q <= redirected_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_valid_d   = pc_valid_q;
        flush_d      = flush_q;
        cnt_d        = cnt_q;
        redirected_d = 1'b0;
        if (step) begin
            case (state_q)
                BOOT: begin
                    state_d    = RUN;
                    pc_valid_d = 1'b1;
                end
                RUN: begin
                    if (bus.branch_taken) begin
                        pc_d         = bus.branch_target_q;
                        pc_valid_d   = 1'b0;
                        flush_d      = 1'b1;
                        cnt_d        = CntInit;
                        redirected_d = 1'b1;
                        state_d      = FLUSH;
                    end else if (bus.halt) begin
                        pc_valid_d = 1'b0;
                        state_d    = HALTED;
                    end else if (pc_valid_q && bus.fetch_ready) begin
                        pc_d = pc_q + AddrBits'(PcIncrement);
                    end
                end
                FLUSH: begin
                    if (cnt_q == '0) begin
                        flush_d    = 1'b0;
                        pc_valid_d = 1'b1;
                        state_d    = RUN;
                    end else begin
                        cnt_d = cnt_q - CntBits'(1);
                    end
                end
                HALTED: begin
                    if (!bus.halt) begin
                        pc_valid_d = 1'b1;
                        state_d    = RUN;
                    end
                end
                default: state_d = BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_branch_target_pc_sequencer.sv
// tb_branch_target_pc_sequencer: scoreboard bench; a behavioural model predicts every post-edge output.
module tb_branch_target_pc_sequencer;
    localparam logic [31:0] WrapVector = 32'hFFFF_FFF8;

    typedef struct packed {
        logic [31:0] pc;
        logic        pv;
        logic        fl;
        logic        red;
    } exp_t;

    typedef enum {M_BOOT, M_RUN, M_FLUSH, M_HALT} m_state_e;

    logic clk = 1'b0;
    logic rst_n;
    logic [31:0] reg_q;
    int n_vec = 0;
    int n_bad = 0;
    exp_t sb[$];
    exp_t mon_e;

    m_state_e    m_st;
    logic [31:0] m_pc;
    logic        m_pv, m_fl, m_red;
    int          m_left;

    always #5 clk = ~clk;

    branch_target_pc_sequencer_if #(.AddrBits(32)) bus ();
    branch_target_pc_sequencer_if #(.AddrBits(32)) wbus ();

    // x stands in for the released (high-Z) register output
    assign bus.branch_target_q = bus.branch_target_cs ? 'x : reg_q;

    assign wbus.ce              = 1'b1;
    assign wbus.tick            = 1'b1;
    assign wbus.branch_taken    = 1'b0;
    assign wbus.branch_target_q = '0;
    assign wbus.halt            = 1'b0;
    assign wbus.fetch_ready     = 1'b1;

    branch_target_pc_sequencer #(
        .AddrBits(32), .PcIncrement(4), .ResetVector(32'h0), .FlushCycles(2)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus)
    );

    branch_target_pc_sequencer #(
        .AddrBits(32), .PcIncrement(4), .ResetVector(WrapVector), .FlushCycles(2)
    ) u_wrap (
        .clk_i(clk), .rst_ni(rst_n), .bus(wbus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic ce, input logic tick, input logic bt,
                         input logic [31:0] q, input logic halt, input logic fr);
        logic step;
        @(negedge clk);
        bus.ce = ce;
        bus.tick = tick;
        bus.branch_taken = bt;
        bus.halt = halt;
        bus.fetch_ready = fr;
        reg_q = q;
        step = ce & tick;
        #1 check("cs", 32'(bus.branch_target_cs), 32'(!(m_st == M_RUN && bt && step)));
        m_red = 1'b0;
        if (step) begin
            case (m_st)
                M_BOOT: begin m_st = M_RUN; m_pv = 1'b1; end
                M_RUN:
                    if (bt) begin
                        m_pc = q; m_pv = 1'b0; m_fl = 1'b1; m_red = 1'b1;
                        m_left = 2; m_st = M_FLUSH;
                    end else if (halt) begin
                        m_pv = 1'b0; m_st = M_HALT;
                    end else if (m_pv && fr) begin
                        m_pc = m_pc + 32'd4;
                    end
                M_FLUSH: begin
                    m_left--;
                    if (m_left == 0) begin m_fl = 1'b0; m_pv = 1'b1; m_st = M_RUN; end
                end
                M_HALT: if (!halt) begin m_pv = 1'b1; m_st = M_RUN; end
            endcase
        end
        sb.push_back('{m_pc, m_pv, m_fl, m_red});
    endtask

    task automatic apply_reset();
        @(negedge clk);
        bus.ce = 1'b1;
        bus.tick = 1'b1;
        bus.branch_taken = 1'b1;
        bus.halt = 1'b0;
        bus.fetch_ready = 1'b1;
        reg_q = 32'h1234;
        rst_n = 1'b0;
        #1;
        check("rst_pc", bus.pc, 32'h0);
        check("rst_pv", 32'(bus.pc_valid), 32'h0);
        check("rst_flush", 32'(bus.flush), 32'h0);
        check("rst_red", 32'(bus.redirected), 32'h0);
        check("rst_cs", 32'(bus.branch_target_cs), 32'h1);
        repeat (2) @(negedge clk);
        check("rst_wrap_pc", wbus.pc, WrapVector);
        m_st = M_BOOT; m_pc = 32'h0; m_pv = 1'b0; m_fl = 1'b0; m_red = 1'b0; m_left = 0;
        bus.ce = 1'b0;
        bus.tick = 1'b0;
        bus.branch_taken = 1'b0;
        bus.fetch_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("pc", bus.pc, mon_e.pc);
            check("pc_valid", 32'(bus.pc_valid), 32'(mon_e.pv));
            check("flush", 32'(bus.flush), 32'(mon_e.fl));
            check("redirected", 32'(bus.redirected), 32'(mon_e.red));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wrap_seq [3];
        wrap_seq = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        rst_n = 1'b0;
        bus.ce = 1'b0; bus.tick = 1'b0; bus.branch_taken = 1'b0;
        bus.halt = 1'b0; bus.fetch_ready = 1'b0; reg_q = '0;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #2 check("wrap_pc", wbus.pc, wrap_seq[k]);
        end
        check("wrap_pv", 32'(wbus.pc_valid), 32'h1);
        // sequential fetch from the reset vector
        repeat (5) drive(1, 1, 0, 0, 0, 1);
        // redirect at 0x10, window stretched by non-step cycles
        drive(1, 1, 1, 32'h200, 0, 1);
        drive(1, 0, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 1);
        drive(1, 1, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 1);
        drive(1, 1, 0, 0, 0, 1);
        drive(1, 1, 0, 0, 0, 1);
        // branch beats halt and fetch-ready; branch ignored in flush
        drive(1, 1, 1, 32'h300, 1, 1);
        drive(1, 1, 1, 32'h999, 1, 1);
        drive(1, 1, 0, 0, 0, 1);
        drive(1, 1, 0, 0, 0, 1);
        // wrap-around through a branch target
        drive(1, 1, 1, WrapVector, 0, 1);
        repeat (2) drive(1, 1, 0, 0, 0, 1);
        repeat (3) drive(1, 1, 0, 0, 0, 1);
        // stall, halt (branch ignored while halted), resume
        drive(1, 1, 1, 32'h40, 0, 1);
        repeat (2) drive(1, 1, 0, 0, 0, 1);
        repeat (5) drive(1, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 1, 0);
        drive(1, 1, 1, 32'h77, 1, 1);
        drive(1, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 1);
        // reset in the middle of a flush window
        drive(1, 1, 1, 32'h500, 0, 1);
        drive(1, 1, 0, 0, 0, 1);
        apply_reset();
        repeat (3) drive(1, 1, 0, 0, 0, 1);
        @(posedge clk);
        #2 check("sb_drain", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
